// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: valid-qualified bit stream in,
// registered one-cycle match pulse and saturating match counter out.
module seq_detect_prog #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1010,
  parameter logic             OVL_RST = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat;
  logic              ovl;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic              acc;
  logic              hit;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_d;
  logic [CNT_W-1:0]  cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? FILL_FULL : f + FILL_W'(1);
  endfunction

  // a bit presented alongside cfg_load is dropped
  always_comb begin
    acc    = din_valid && !cfg_load;
    hist_n = {hist[PAT_W-2:0], din};
    fill_n = fill_inc(fill);
    hit    = acc && (fill_n == FILL_FULL) && (hist_n == pat);

    hist_d = hist;
    fill_d = fill;
    if (cfg_load || (hit && !ovl)) begin
      hist_d = '0;
      fill_d = '0;
    end else if (acc) begin
      hist_d = hist_n;
      fill_d = fill_n;
    end

    cnt_d = match_count;
    if (cnt_clr)
      cnt_d = '0;
    else if (hit)
      cnt_d = sat_inc(match_count);
  end

  // registered outputs: match pulse lands one edge after the final pattern bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat         <= PAT_RST;
      ovl         <= OVL_RST;
      hist        <= '0;
      fill        <= '0;
      dout        <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      if (cfg_load) begin
        pat <= cfg_pattern;
        ovl <= cfg_overlap;
      end
      hist        <= hist_d;
      fill        <= fill_d;
      dout        <= hit;
      match_count <= cnt_d;
      count_sat   <= &cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: two instances (8-bit and 2-bit counters) share stimulus
// and are compared against a queue-based reference model every cycle.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       dout_a, sat_a;
  logic [7:0] cnt_a;
  logic       dout_b, sat_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1010), .OVL_RST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1010), .OVL_RST(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .dout(dout_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  // reference model: the received bits since the last restart, matched against the pattern
  int         m_bits[$];
  logic [3:0] m_pat;
  bit         m_ovl;
  int         m_dout;
  int         m_c8;
  int         m_c2;

  task automatic model_reset();
    m_bits.delete();
    m_pat  = 4'b1010;
    m_ovl  = 1'b1;
    m_dout = 0;
    m_c8   = 0;
    m_c2   = 0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic cl,
                            input logic [3:0] cp, input logic co, input logic cc);
    bit hit;
    hit = 1'b0;
    if (cl) begin
      m_pat = cp;
      m_ovl = co;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() == 4) begin
        hit = 1'b1;
        for (int i = 0; i < 4; i++)
          if (m_bits[i] != int'(m_pat[3-i])) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    m_dout = hit ? 1 : 0;
    if (cc) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (hit) begin
      m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
      m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_model();
    check("dout_a", int'(dout_a), m_dout);
    check("cnt_a", int'(cnt_a), m_c8);
    check("sat_a", int'(sat_a), (m_c8 == 255) ? 1 : 0);
    check("dout_b", int'(dout_b), m_dout);
    check("cnt_b", int'(cnt_b), m_c2);
    check("sat_b", int'(sat_b), (m_c2 == 3) ? 1 : 0);
  endtask

  task automatic step(input logic v, input logic d, input logic cl,
                      input logic [3:0] cp, input logic co, input logic cc);
    din_valid   = v;
    din         = d;
    cfg_load    = cl;
    cfg_pattern = cp;
    cfg_overlap = co;
    cnt_clr     = cc;
    @(posedge clk);
    model_step(v, d, cl, cp, co, cc);
    #1;
    check_all_model();
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic bit_in(input logic d);
    step(1'b1, d, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_dout", int'(dout_a) + int'(dout_b), 0);
    check("rst_cnt", int'(cnt_a) + int'(cnt_b), 0);
    check("rst_sat", int'(sat_a) + int'(sat_b), 0);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       v, d, cl;
    logic [3:0] cp;
    logic       co, cc;
    int         e_dout, e_c8, e_c2;
  } vec_t;

  vec_t tbl[14];

  int pulses;
  int k;
  int exp_c2[6];

  initial begin
    // defaults 1010 overlapping, then reload 1010 non-overlapping, then clear
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1, 1, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1, 2, 2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 0, 2, 2};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 2, 2};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 2, 2};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 2, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1, 3, 3};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0, 3, 3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 0, 3, 3};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 0, 0, 0};
    exp_c2 = '{1, 2, 3, 3, 3, 3};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].cl, tbl[i].cp, tbl[i].co, tbl[i].cc);
      check($sformatf("tbl%0d_dout", i), int'(dout_a), tbl[i].e_dout);
      check($sformatf("tbl%0d_cnt8", i), int'(cnt_a), tbl[i].e_c8);
      check($sformatf("tbl%0d_cnt2", i), int'(cnt_b), tbl[i].e_c2);
      check($sformatf("tbl%0d_sat2", i), int'(sat_b), (tbl[i].e_c2 == 3) ? 1 : 0);
    end

    // valid gaps between bits 2 and 3
    do_reset();
    pulses = 0;
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b0); pulses += int'(dout_a);
    for (int i = 0; i < 3; i++) begin idle(); pulses += int'(dout_a); end
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b0);
    check("gap_pulse", int'(dout_a), 1);
    check("gap_early", pulses, 0);

    // asynchronous reset mid-stream wipes history
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    reset = 1'b1;
    #2;
    check("async_dout", int'(dout_a), 0);
    check("async_cnt", int'(cnt_a), 0);
    din_valid = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    check("inrst_dout", int'(dout_a), 0);
    din_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    pulses = 0;
    bit_in(1'b0); pulses += int'(dout_a);
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b0); pulses += int'(dout_a);
    check("postrst_pulses", pulses, 0);

    // saturation of the 2-bit counter over six overlapping matches
    do_reset();
    k = 0;
    for (int i = 0; i < 14; i++) begin
      bit_in((i % 2 == 0) ? 1'b1 : 1'b0);
      if (dout_b && k < 6) begin
        check($sformatf("sat_cnt%0d", k), int'(cnt_b), exp_c2[k]);
        check($sformatf("sat_flag%0d", k), int'(sat_b), (k >= 2) ? 1 : 0);
        k++;
      end
    end
    check("sat_matches", k, 6);
    bit_in(1'b1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("clrhit_dout", int'(dout_b), 1);
    check("clrhit_cnt2", int'(cnt_b), 0);
    check("clrhit_sat2", int'(sat_b), 0);
    check("clrhit_cnt8", int'(cnt_a), 0);

    // bit alongside cfg_load is dropped
    do_reset();
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
    bit_in(1'b0); pulses += int'(dout_a);
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b0); pulses += int'(dout_a);
    check("load_pulses", pulses, 1);
    check("load_last", int'(dout_a), 1);
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b1); pulses += int'(dout_a);
    bit_in(1'b0); pulses += int'(dout_a);
    check("drop_pulses", pulses, 0);

    // randomized traffic including reloads and clears
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic       v, d, cl, co, cc;
      logic [3:0] cp;
      v  = ($urandom_range(0, 9) < 7);
      d  = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 39) == 0);
      cp = 4'($urandom_range(0, 15));
      co = 1'($urandom_range(0, 1));
      cc = ($urandom_range(0, 49) == 0);
      step(v, d, cl, cp, co, cc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
